// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED receive path: FSM states, status
// flag encodings and the bit layout of the 16-bit encoded word.
package hamming_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAPT,
    S_DEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_SEC = 2'b01;
  localparam logic [1:0] F_DED = 2'b10;

  localparam int WORD_W       = 16;
  localparam int POS_D1       = 3;
  localparam int POS_D4_2_LO  = 5;
  localparam int POS_D4_2_HI  = 7;
  localparam int POS_D11_5_LO = 9;
  localparam int POS_D11_5_HI = 15;

  // Gathers d11..d1 out of the interleaved code word, d1 landing in bit 1.
  function automatic logic [11:1] extract_data(input logic [WORD_W-1:0] w);
    return {w[POS_D11_5_HI:POS_D11_5_LO], w[POS_D4_2_HI:POS_D4_2_LO], w[POS_D1]};
  endfunction

endpackage

// File: rtl/secded_decode.sv
// Combinational SECDED decode of one 16-bit word: syndrome plus overall
// parity pick between pass-through, single-bit correction and double-error flag.
module secded_decode
  import hamming_pkg::*;
(
  input  logic [15:0] w,
  output logic [11:1] d,
  output logic [1:0]  f
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = '0;
    for (int k = 1; k < WORD_W; k++) begin
      if (w[k]) syn ^= 4'(k);
    end
    par   = ^w;
    fixed = w;
    f     = F_OK;
    // A zero syndrome with odd parity means p0 itself flipped; toggling bit 0 leaves data intact.
    if (par) begin
      f          = F_SEC;
      fixed[syn] = ~w[syn];
    end else if (syn != 4'd0) begin
      f = F_DED;
    end
    d = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Memory-attached SECDED decoder: walks NUM_MSG encoded words, decodes each
// and writes back the 11-bit data with a 2-bit status in the top byte.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int ADDR_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req,
  output logic              Done,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_wr_en,
  output logic [7:0]        Mem_wdata,
  input  logic [7:0]        Mem_rdata
);

  localparam int              IDX_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  index;
  logic [7:0]        word_lo;
  logic [7:0]        word_hi;
  logic [11:1]       dec_d;
  logic [1:0]        dec_f;
  logic [11:1]       dec_data;
  logic [1:0]        dec_flag;
  logic              accept;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign accept   = ((state == S_IDLE) || (state == S_DONE)) && Req;
  assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'({index, 1'b0});
  assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'({index, 1'b0});

  secded_decode u_decode (
    .w (({word_hi, word_lo})),
    .d (dec_d),
    .f (dec_f)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (Req) next_state = S_RD_LO;
      S_RD_LO:        next_state = S_RD_HI;
      S_RD_HI:        next_state = S_CAPT;
      S_CAPT:         next_state = S_DEC;
      S_DEC:          next_state = S_WR_LO;
      S_WR_LO:        next_state = S_WR_HI;
      S_WR_HI:        next_state = (index == LAST_IDX) ? S_DONE : S_RD_LO;
      default:        next_state = S_IDLE;
    endcase
  end

  // Read data trails the address by one cycle, so each byte is captured in the state after its address.
  always_comb begin
    Mem_addr  = '0;
    Mem_wr_en = 1'b0;
    Mem_wdata = '0;
    case (state)
      S_RD_LO: Mem_addr = src_addr;
      S_RD_HI: Mem_addr = src_addr + ADDR_W'(1);
      S_WR_LO: begin
        Mem_addr  = dst_addr;
        Mem_wr_en = 1'b1;
        Mem_wdata = dec_data[8:1];
      end
      S_WR_HI: begin
        Mem_addr  = dst_addr + ADDR_W'(1);
        Mem_wr_en = 1'b1;
        Mem_wdata = {dec_flag, 3'b000, dec_data[11:9]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      index    <= '0;
      Done     <= 1'b0;
      word_lo  <= '0;
      word_hi  <= '0;
      dec_data <= '0;
      dec_flag <= F_OK;
    end else begin
      if (accept) begin
        index <= '0;
        Done  <= 1'b0;
      end else begin
        if (state == S_DONE) Done <= 1'b1;
        if ((state == S_WR_HI) && (index != LAST_IDX)) index <= index + IDX_W'(1);
      end
      if (state == S_RD_HI) word_lo <= Mem_rdata;
      if (state == S_CAPT)  word_hi <= Mem_rdata;
      if (state == S_DEC) begin
        dec_data <= dec_d;
        dec_flag <= dec_f;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomised self-checking bench: messages are built by a Hamming encoder model
// with injected flips, and every DUT write is compared with the model's bytes.
module tb_hamming_secded_decoder;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 30;
  localparam int DST_BASE = 0;
  localparam int ADDR_W   = 8;

  logic              Clk;
  logic              Reset_n;
  logic              Req;
  logic              Done;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_wr_en;
  logic [7:0]        Mem_wdata;
  logic [7:0]        Mem_rdata;

  logic [7:0]        mem [256];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;

  logic [15:0] msg_word [NUM_MSG];
  logic [7:0]  exp_lo   [NUM_MSG];
  logic [7:0]  exp_hi   [NUM_MSG];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [7:0]        exp_data[$];

  logic [15:0] lit_word [4] = '{16'h000F, 16'h100F, 16'h000E, 16'h102F};
  logic [7:0]  lit_lo   [4] = '{8'h01, 8'h01, 8'h01, 8'h83};
  logic [7:0]  lit_hi   [4] = '{8'h00, 8'h40, 8'h40, 8'h80};

  int checks;
  int errors;
  int write_count;

  hamming_secded_decoder #(
    .NUM_MSG  (NUM_MSG),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Req       (Req),
    .Done      (Done),
    .Mem_addr  (Mem_addr),
    .Mem_wr_en (Mem_wr_en),
    .Mem_wdata (Mem_wdata),
    .Mem_rdata (Mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read byte memory; the bench preloads it through its own port.
  always @(posedge Clk) begin
    if (ld_en)          mem[ld_addr]  <= ld_data;
    else if (Mem_wr_en) mem[Mem_addr] <= Mem_wdata;
    Mem_rdata <= mem[Mem_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Hamming encoder: data fills non-power-of-two positions, parity bits zero the syndrome.
  function automatic logic [15:0] encode(input logic [10:0] data);
    logic [15:0] w;
    logic        p;
    int          n;
    w = '0;
    n = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k] = data[n];
        n++;
      end
    end
    for (int j = 1; j < 16; j = j * 2) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if (((k & j) != 0) && (k != j)) p ^= w[k];
      w[j] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] data;
    int          n;
    data = '0;
    n = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        data[n] = w[k];
        n++;
      end
    end
    return data;
  endfunction

  task automatic loadByte(input int addr, input logic [7:0] data);
    @(negedge Clk);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(addr);
    ld_data = data;
    @(negedge Clk);
    ld_en   = 1'b0;
  endtask

  // Builds NUM_MSG messages (0, 1 or 2 flipped bits), loads them and records expected bytes.
  task automatic applyStimulus(input bit with_literals);
    for (int i = 0; i < NUM_MSG; i++) begin
      logic [10:0] data;
      logic [15:0] w;
      logic [1:0]  flag;
      int          a;
      int          b;
      if (with_literals && (i < 4)) begin
        w         = lit_word[i];
        exp_lo[i] = lit_lo[i];
        exp_hi[i] = lit_hi[i];
      end else begin
        data = 11'($urandom);
        w    = encode(data);
        a    = $urandom_range(0, 15);
        b    = (a + $urandom_range(1, 15)) % 16;
        flag = 2'(i % 3);
        if (flag != 2'd0) w[a] = ~w[a];
        if (flag == 2'd2) begin
          w[b] = ~w[b];
          data = extract(w);
        end
        exp_lo[i] = data[7:0];
        exp_hi[i] = {flag, 3'b000, data[10:8]};
      end
      msg_word[i] = w;
      loadByte(SRC_BASE + 2 * i, w[7:0]);
      loadByte(SRC_BASE + 2 * i + 1, w[15:8]);
    end
  endtask

  task automatic pushExpected();
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < NUM_MSG; i++) begin
      exp_addr.push_back(ADDR_W'(DST_BASE + 2 * i));
      exp_data.push_back(exp_lo[i]);
      exp_addr.push_back(ADDR_W'(DST_BASE + 2 * i + 1));
      exp_data.push_back(exp_hi[i]);
    end
  endtask

  // Pulses Req and counts edges until Done; optionally pulses Req again mid-run.
  task automatic runRequest(input bit mid_req, output int cycles);
    @(negedge Clk);
    Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    cycles = 0;
    while (cycles < 500) begin
      @(posedge Clk);
      cycles++;
      #1;
      Req = mid_req && (cycles == 40);
      if (Done) break;
    end
    Req = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (Reset_n && Mem_wr_en) begin
      write_count++;
      if (exp_addr.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        checkOutput("write_addr", int'(Mem_addr), int'(exp_addr.pop_front()));
        checkOutput("write_data", int'(Mem_wdata), int'(exp_data.pop_front()));
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cycles;
    bit  found;
    checks      = 0;
    errors      = 0;
    write_count = 0;
    Reset_n     = 1'b0;
    Req         = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_done", Done, 0);
    checkOutput("reset_wr_en", Mem_wr_en, 0);
    checkOutput("reset_addr", Mem_addr, 0);
    checkOutput("reset_wdata", Mem_wdata, 0);
    checkOutput("model_encode_one", encode(11'h001), 16'h000F);
    @(negedge Clk);
    Reset_n = 1'b1;

    $display("[TB] run A: literal vectors plus random messages, mid-run Req");
    applyStimulus(1'b1);
    pushExpected();
    write_count = 0;
    runRequest(1'b1, cycles);
    checkOutput("done_latency_a", cycles, 6 * NUM_MSG + 1);
    checkOutput("write_pulses_a", write_count, 2 * NUM_MSG);
    checkOutput("pending_writes_a", exp_addr.size(), 0);
    checkOutput("mem0_clean", mem[0], 8'h01);
    checkOutput("mem1_clean", mem[1], 8'h00);
    checkOutput("mem2_sec_data", mem[2], 8'h01);
    checkOutput("mem3_sec_data", mem[3], 8'h40);
    checkOutput("mem4_sec_p0", mem[4], 8'h01);
    checkOutput("mem5_sec_p0", mem[5], 8'h40);
    checkOutput("mem6_ded", mem[6], 8'h83);
    checkOutput("mem7_ded", mem[7], 8'h80);
    repeat (3) @(posedge Clk);
    #1 checkOutput("done_held", Done, 1);

    $display("[TB] run B: reset asserted during message 3 low write");
    for (int a = 0; a < 2 * NUM_MSG; a++) loadByte(DST_BASE + a, 8'hA5);
    applyStimulus(1'b0);
    pushExpected();
    write_count = 0;
    @(negedge Clk);
    Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    checkOutput("done_cleared_on_accept", Done, 0);
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge Clk);
      #1;
      if (Mem_wr_en && (Mem_addr == ADDR_W'(DST_BASE + 6))) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_msg3_wr_lo", found, 1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("async_rst_wr_en", Mem_wr_en, 0);
    checkOutput("async_rst_addr", Mem_addr, 0);
    checkOutput("async_rst_wdata", Mem_wdata, 0);
    checkOutput("async_rst_done", Done, 0);
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("writes_before_reset", write_count, 6);
    for (int i = 0; i < 3; i++) begin
      checkOutput("intact_lo", mem[DST_BASE + 2 * i], exp_lo[i]);
      checkOutput("intact_hi", mem[DST_BASE + 2 * i + 1], exp_hi[i]);
    end
    checkOutput("no_write_msg3_lo", mem[DST_BASE + 6], 8'hA5);
    checkOutput("no_write_msg3_hi", mem[DST_BASE + 7], 8'hA5);
    exp_addr.delete();
    exp_data.delete();
    @(negedge Clk);
    Reset_n = 1'b1;

    $display("[TB] run C: fresh request after reset");
    pushExpected();
    write_count = 0;
    runRequest(1'b0, cycles);
    checkOutput("done_latency_c", cycles, 6 * NUM_MSG + 1);
    checkOutput("write_pulses_c", write_count, 2 * NUM_MSG);
    checkOutput("pending_writes_c", exp_addr.size(), 0);
    checkOutput("msg3_lo_after_rerun", mem[DST_BASE + 6], exp_lo[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
